// File: rtl/uidbuf_mc_wsched.sv
// Multi-channel write-side frame-buffer scheduler: per-channel frame FSMs and a one-burst-at-a-time FDMA arbiter.
// Define UIDBUF_MC_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module uidbuf_mc_wsched #(
    parameter int                        CH_NUM         = 4,
    parameter int                        AXI_DATA_WIDTH = 128,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        BURST_LEN      = 256,
    parameter int                        FRAME_BURSTS   = 1620,
    parameter int                        DSIZEBITS      = 23,
    parameter int                        BUFSIZE        = 3,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASEADDR       = '0,
    parameter int                        RST_CYCLES     = 60,
    parameter int                        IRQ_HOLD       = 60,
    localparam int                       GW             = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic [CH_NUM-1:0]         ch_fs_i,
    input  logic [CH_NUM-1:0]         ch_req_i,
    output logic [CH_NUM-1:0]         ch_fifo_rst_o,
    output logic [CH_NUM-1:0]         ch_rd_o,
    output logic [8*CH_NUM-1:0]       ch_buf_o,
    output logic [CH_NUM-1:0]         ch_irq_o,
    output logic [CH_NUM-1:0]         ch_ovf_o,
    output logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
    output logic                      fdma_wareq,
    output logic [15:0]               fdma_wsize,
    input  logic                      fdma_wbusy,
    input  logic                      fdma_wvalid,
    output logic                      fdma_wready,
    output logic [GW-1:0]             grant_o
);
    localparam int BW     = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int SETTLE = 40;
    localparam int TMAX   = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int IW     = $clog2(IRQ_HOLD + 1);
    localparam longint unsigned BURST_BYTES = longint'(BURST_LEN) * longint'(AXI_DATA_WIDTH) / 8;

    localparam logic [TW-1:0] FLUSH_LAST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [BW-1:0] LAST_BURST  = BW'(FRAME_BURSTS - 1);
    localparam logic [IW-1:0] IRQ_LOAD    = IW'(IRQ_HOLD);
    localparam logic [7:0]    BUF_LAST    = 8'(BUFSIZE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_BUSY = 2'd2;

    logic [1:0]    st_q   [CH_NUM];
    logic [1:0]    st_d   [CH_NUM];
    logic [TW-1:0] tmr_q  [CH_NUM];
    logic [TW-1:0] tmr_d  [CH_NUM];
    logic [BW-1:0] bcnt_q [CH_NUM];
    logic [BW-1:0] bcnt_d [CH_NUM];
    logic [7:0]    bufi_q [CH_NUM];
    logic [7:0]    bufi_d [CH_NUM];
    logic [IW-1:0] irq_q  [CH_NUM];
    logic [IW-1:0] irq_d  [CH_NUM];
    logic [CH_NUM-1:0] pend_q, pend_d, ovf_q, ovf_d;
    logic [CH_NUM-1:0] in_flight, done, eligible;

    logic [1:0]                arb_q, arb_d;
    logic [GW-1:0]             grant_q, grant_d, sel;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      sel_found;
`ifndef UIDBUF_MC_PRIO_EN
    logic [GW-1:0]             rr_q, rr_d;
`endif

    function automatic logic [AXI_ADDR_WIDTH-1:0] burst_addr(input logic [GW-1:0] ch,
                                                            input logic [7:0] b,
                                                            input logic [BW-1:0] n);
        logic [63:0] a;
        a = 64'(BASEADDR) + (64'(ch) << (DSIZEBITS + 3)) + (64'(b) << DSIZEBITS)
            + 64'(n) * 64'(BURST_BYTES);
        return a[AXI_ADDR_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            in_flight[c] = (arb_q != ARB_IDLE) && (grant_q == GW'(c));
            done[c]      = (arb_q == ARB_BUSY) && !fdma_wbusy && (grant_q == GW'(c));
            // A channel seeing fs this cycle is about to leave ACTIVE, so it must not be picked.
            eligible[c]  = (st_q[c] == ST_ACTIVE) && ch_req_i[c] && !ch_fs_i[c] && !pend_q[c];
        end
    end

    always_comb begin
        logic go_flush;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            go_flush  = 1'b0;
            st_d[c]   = st_q[c];
            tmr_d[c]  = tmr_q[c];
            bcnt_d[c] = bcnt_q[c];
            bufi_d[c] = bufi_q[c];
            pend_d[c] = pend_q[c];
            ovf_d[c]  = 1'b0;
            irq_d[c]  = (irq_q[c] != '0) ? irq_q[c] - IW'(1) : '0;
            case (st_q[c])
                ST_IDLE: begin
                    if (ch_fs_i[c] || pend_q[c]) go_flush = 1'b1;
                end
                ST_FLUSH: begin
                    if (ch_fs_i[c]) tmr_d[c] = '0;
                    else if (tmr_q[c] == FLUSH_LAST) begin
                        st_d[c]  = ST_WAIT;
                        tmr_d[c] = '0;
                    end else tmr_d[c] = tmr_q[c] + TW'(1);
                end
                ST_WAIT: begin
                    // Restarting the flush keeps the buffer already chosen for this frame.
                    if (ch_fs_i[c]) begin
                        st_d[c]  = ST_FLUSH;
                        tmr_d[c] = '0;
                    end else if (irq_q[c] != '0) tmr_d[c] = '0;
                    else if (tmr_q[c] == SETTLE_LAST) st_d[c] = ST_ACTIVE;
                    else tmr_d[c] = tmr_q[c] + TW'(1);
                end
                default: begin
                    if (done[c]) begin
                        if (bcnt_q[c] == LAST_BURST) begin
                            st_d[c]   = ST_IDLE;
                            bcnt_d[c] = '0;
                            irq_d[c]  = IRQ_LOAD;
                            pend_d[c] = pend_q[c] | ch_fs_i[c];
                        end else if (ch_fs_i[c] || pend_q[c]) begin
                            ovf_d[c]  = 1'b1;
                            bcnt_d[c] = '0;
                            go_flush  = 1'b1;
                        end else bcnt_d[c] = bcnt_q[c] + BW'(1);
                    end else if (in_flight[c]) begin
                        if (ch_fs_i[c]) pend_d[c] = 1'b1;
                    end else if (ch_fs_i[c]) begin
                        ovf_d[c]  = 1'b1;
                        bcnt_d[c] = '0;
                        go_flush  = 1'b1;
                    end
                end
            endcase
            if (go_flush) begin
                st_d[c]   = ST_FLUSH;
                tmr_d[c]  = '0;
                pend_d[c] = 1'b0;
                bufi_d[c] = (bufi_q[c] == BUF_LAST) ? 8'd0 : bufi_q[c] + 8'd1;
            end
        end
    end

    always_comb begin
        int unsigned idx;
        sel_found = 1'b0;
        sel       = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
`ifdef UIDBUF_MC_PRIO_EN
            idx = i;
`else
            idx = int'(rr_q) + i;
            if (idx >= CH_NUM) idx = idx - CH_NUM;
`endif
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel       = GW'(idx);
            end
        end
    end

    always_comb begin
        arb_d   = arb_q;
        grant_d = grant_q;
        addr_d  = addr_q;
`ifndef UIDBUF_MC_PRIO_EN
        rr_d    = rr_q;
`endif
        case (arb_q)
            ARB_IDLE: begin
                if (sel_found) begin
                    arb_d   = ARB_REQ;
                    grant_d = sel;
                    addr_d  = burst_addr(sel, bufi_q[sel], bcnt_q[sel]);
`ifndef UIDBUF_MC_PRIO_EN
                    rr_d    = (sel == GW'(CH_NUM - 1)) ? '0 : sel + GW'(1);
`endif
                end
            end
            ARB_REQ:  if (fdma_wbusy) arb_d = ARB_BUSY;
            ARB_BUSY: if (!fdma_wbusy) arb_d = ARB_IDLE;
            default:  arb_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                st_q[c]   <= ST_IDLE;
                tmr_q[c]  <= '0;
                bcnt_q[c] <= '0;
                bufi_q[c] <= '0;
                irq_q[c]  <= '0;
            end
            pend_q  <= '0;
            ovf_q   <= '0;
            arb_q   <= ARB_IDLE;
            grant_q <= '0;
            addr_q  <= '0;
`ifndef UIDBUF_MC_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                st_q[c]   <= st_d[c];
                tmr_q[c]  <= tmr_d[c];
                bcnt_q[c] <= bcnt_d[c];
                bufi_q[c] <= bufi_d[c];
                irq_q[c]  <= irq_d[c];
            end
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            arb_q   <= arb_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
`ifndef UIDBUF_MC_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            ch_fifo_rst_o[c]  = (st_q[c] == ST_FLUSH);
            ch_irq_o[c]       = (irq_q[c] != '0);
            ch_buf_o[8*c +: 8] = bufi_q[c];
            // Gated by arbiter activity so a stray wvalid cannot drain a FIFO with no burst owned.
            ch_rd_o[c]        = fdma_wvalid && (arb_q != ARB_IDLE) && (grant_q == GW'(c));
        end
    end

    assign ch_ovf_o    = ovf_q;
    assign fdma_wareq  = (arb_q == ARB_REQ) && !fdma_wbusy;
    assign fdma_waddr  = addr_q;
    assign fdma_wsize  = 16'(BURST_LEN);
    assign fdma_wready = 1'b1;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_uidbuf_mc_wsched.sv
// Self-checking bench for uidbuf_mc_wsched: randomized FDMA timing and request patterns against an address/buffer model.
module tb_uidbuf_mc_wsched;
    localparam int          CH   = 3;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          BL   = 8;
    localparam int          FB   = 4;
    localparam int          DS   = 12;
    localparam int          NBUF = 3;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          RSTC = 6;
    localparam int          IRQH = 5;
    localparam int          GW   = 2;

    logic            ui_clk = 1'b0;
    logic            ui_rst;
    logic [CH-1:0]   ch_fs_i, ch_req_i;
    logic [CH-1:0]   ch_fifo_rst_o, ch_rd_o, ch_irq_o, ch_ovf_o;
    logic [8*CH-1:0] ch_buf_o;
    logic [AW-1:0]   fdma_waddr;
    logic            fdma_wareq, fdma_wbusy, fdma_wvalid, fdma_wready;
    logic [15:0]     fdma_wsize;
    logic [GW-1:0]   grant_o;

    uidbuf_mc_wsched #(
        .CH_NUM(CH), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .BURST_LEN(BL),
        .FRAME_BURSTS(FB), .DSIZEBITS(DS), .BUFSIZE(NBUF), .BASEADDR(BASE),
        .RST_CYCLES(RSTC), .IRQ_HOLD(IRQH)
    ) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst), .ch_fs_i(ch_fs_i), .ch_req_i(ch_req_i),
        .ch_fifo_rst_o(ch_fifo_rst_o), .ch_rd_o(ch_rd_o), .ch_buf_o(ch_buf_o),
        .ch_irq_o(ch_irq_o), .ch_ovf_o(ch_ovf_o), .fdma_waddr(fdma_waddr),
        .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize), .fdma_wbusy(fdma_wbusy),
        .fdma_wvalid(fdma_wvalid), .fdma_wready(fdma_wready), .grant_o(grant_o)
    );

    always #5 ui_clk = ~ui_clk;

    int          errors = 0;
    int          checks = 0;
    int          lg_ch[$];
    logic [31:0] lg_ad[$];
    int          gseq[$];
    int          mbuf[CH], mbcnt[CH], bcount[CH];
    int          irq_rise[CH], ovf_cnt[CH], flush_cyc[CH];
    int          nburst = 0;
    int          rd_bad = 0;

    function automatic logic [31:0] exp_addr(input int c, input int b, input int n);
        longint unsigned a;
        a = longint'(BASE) + longint'(c) * (longint'(1) << (DS + 3)) + longint'(b) * (longint'(1) << DS)
            + longint'(n) * BL * DW / 8;
        return a[31:0];
    endfunction

    function automatic logic [7:0] buf_of(input int c);
        return ch_buf_o[8*c +: 8];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every burst request the FDMA side saw is checked against the model's buffer and burst index.
    task automatic drain();
        int c;
        logic [31:0] a;
        while (lg_ch.size() > 0) begin
            c = lg_ch.pop_front();
            a = lg_ad.pop_front();
            chk($sformatf("addr_ch%0d_b%0d", c, mbcnt[c]), 64'(a), 64'(exp_addr(c, mbuf[c], mbcnt[c])));
            gseq.push_back(c);
            mbcnt[c] = (mbcnt[c] + 1 == FB) ? 0 : mbcnt[c] + 1;
            bcount[c]++;
            nburst++;
        end
    endtask

    task automatic fs_pulse(input logic [CH-1:0] mask);
        drain();
        for (int c = 0; c < CH; c++)
            if (mask[c]) begin
                mbuf[c]  = (mbuf[c] + 1) % NBUF;
                mbcnt[c] = 0;
            end
        ch_fs_i = mask;
        @(negedge ui_clk);
        ch_fs_i = '0;
    endtask

    task automatic wait_nburst(input int target, input int budget, input string tag);
        int t = 0;
        drain();
        while (nburst < target && t < budget) begin
            @(negedge ui_clk);
            drain();
            t++;
        end
        chk(tag, 64'(nburst), 64'(target));
    endtask

    task automatic wait_irq(input int c, input int target, input int budget, input string tag);
        int t = 0;
        while (irq_rise[c] < target && t < budget) begin
            @(negedge ui_clk);
            drain();
            t++;
        end
        chk(tag, 64'(irq_rise[c]), 64'(target));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ui_clk);
            drain();
        end
    endtask

    initial begin : monitor
        logic [CH-1:0] irq_prev = '0;
        for (int c = 0; c < CH; c++) begin
            irq_rise[c] = 0; ovf_cnt[c] = 0; flush_cyc[c] = 0;
        end
        forever begin
            @(negedge ui_clk);
            for (int c = 0; c < CH; c++) begin
                if (ch_irq_o[c] && !irq_prev[c]) irq_rise[c]++;
                if (ch_ovf_o[c]) ovf_cnt[c]++;
                if (ch_fifo_rst_o[c]) flush_cyc[c]++;
            end
            irq_prev = ch_irq_o;
        end
    end

    initial begin : fdma_model
        int g, dly, beats;
        logic [CH-1:0] exp_rd;
        fdma_wbusy  = 1'b0;
        fdma_wvalid = 1'b0;
        forever begin
            @(negedge ui_clk);
            if (!ui_rst && fdma_wareq) begin
                g = int'(grant_o);
                lg_ch.push_back(g);
                lg_ad.push_back(fdma_waddr);
                dly = $urandom_range(0, 2);
                for (int i = 0; i < dly; i++) @(negedge ui_clk);
                fdma_wbusy = 1'b1;
                beats = 0;
                while (beats < BL) begin
                    @(negedge ui_clk);
                    if (ui_rst) break;
                    fdma_wvalid = ($urandom_range(0, 3) != 0);
                    if (fdma_wvalid) beats++;
                    #1;
                    exp_rd = fdma_wvalid ? (CH'(1) << g) : '0;
                    if (!ui_rst && ch_rd_o !== exp_rd) rd_bad++;
                end
                @(negedge ui_clk);
                fdma_wvalid = 1'b0;
                fdma_wbusy  = 1'b0;
            end
        end
    end

    initial begin : main
        int t, b0, i0, o0, i2, base;
        int ib[CH];
        logic [CH-1:0] rmask;
        for (int c = 0; c < CH; c++) begin
            mbuf[c] = 0; mbcnt[c] = 0; bcount[c] = 0;
        end
        ui_rst   = 1'b1;
        ch_fs_i  = '0;
        ch_req_i = '0;
        repeat (3) @(negedge ui_clk);

        // Reset state
        chk("rst_wareq", 64'(fdma_wareq), 64'(0));
        chk("rst_wready", 64'(fdma_wready), 64'(1));
        chk("rst_wsize", 64'(fdma_wsize), 64'(BL));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_buf", 64'(ch_buf_o), 64'(0));
        chk("rst_irq_ovf_fifo", 64'({ch_irq_o, ch_ovf_o, ch_fifo_rst_o, ch_rd_o}), 64'(0));
        chk("rst_waddr", 64'(fdma_waddr), 64'(0));
        ui_rst = 1'b0;
        @(negedge ui_clk);

        // Two channels always requesting, simultaneous frame start
        ch_req_i = 3'b011;
        gseq.delete();
        fs_pulse(3'b011);
        wait_nburst(8, 3000, "t1_bursts");
        for (int k = 0; k < 8; k++) begin
`ifdef UIDBUF_MC_PRIO_EN
            chk($sformatf("t1_grant%0d", k), 64'(gseq[k]), 64'((k < 4) ? 0 : 1));
`else
            chk($sformatf("t1_grant%0d", k), 64'(gseq[k]), 64'(k % 2));
`endif
        end
        wait_irq(0, 1, 200, "t1_irq0");
        wait_irq(1, 1, 200, "t1_irq1");
        chk("t1_buf0", 64'(buf_of(0)), 64'(1));
        chk("t1_buf1", 64'(buf_of(1)), 64'(1));
        chk("t1_buf2", 64'(buf_of(2)), 64'(0));
        chk("t1_flush_len", 64'(flush_cyc[0]), 64'(RSTC));
        chk("t1_no_ovf", 64'(ovf_cnt[0] + ovf_cnt[1]), 64'(0));

        // One channel, three consecutive frames: buffers 1,2,0
        ch_req_i = 3'b100;
        for (int f = 0; f < 3; f++) begin
            fs_pulse(3'b100);
            tick(2);
            chk($sformatf("t2_buf_f%0d", f), 64'(buf_of(2)), 64'((f + 1) % 3));
            wait_nburst(nburst + FB, 2000, "t2_bursts");
            wait_irq(2, f + 1, 200, "t2_irq");
        end

        // Frame start on channel 1 while its second burst is in flight
        ch_req_i = 3'b010;
        fs_pulse(3'b010);
        t = 0;
        while (!(mbcnt[1] == 2 && fdma_wbusy) && t < 1000) begin
            @(negedge ui_clk);
            drain();
            t++;
        end
        chk("t3_midburst", 64'(mbcnt[1] == 2 && fdma_wbusy), 64'(1));
        o0 = ovf_cnt[1];
        i0 = irq_rise[1];
        fs_pulse(3'b010);
        t = 0;
        while (ovf_cnt[1] == o0 && t < 200) begin
            @(negedge ui_clk);
            drain();
            t++;
        end
        tick(3);
        chk("t3_ovf_once", 64'(ovf_cnt[1]), 64'(o0 + 1));
        chk("t3_no_irq", 64'(irq_rise[1]), 64'(i0));
        chk("t3_buf", 64'(buf_of(1)), 64'(0));
        wait_nburst(nburst + FB, 2000, "t3_restart_bursts");
        wait_irq(1, i0 + 1, 200, "t3_irq");

        // Channel 0 stops requesting mid-frame while channel 2 keeps running
        ch_req_i = 3'b101;
        i2 = irq_rise[2];
        i0 = irq_rise[0];
        fs_pulse(3'b101);
        t = 0;
        while (mbcnt[0] != 2 && t < 1000) begin
            @(negedge ui_clk);
            drain();
            t++;
        end
        ch_req_i[0] = 1'b0;
        b0 = bcount[0];
        chk("t4_reach", 64'(mbcnt[0]), 64'(2));
        tick(500);
        chk("t4_no_grant", 64'(bcount[0]), 64'(b0));
        chk("t4_other_done", 64'(irq_rise[2]), 64'(i2 + 1));
        ch_req_i[0] = 1'b1;
        wait_irq(0, i0 + 1, 1000, "t4_irq0");
        chk("t4_resume_cnt", 64'(bcount[0]), 64'(b0 + 2));

        // Random request patterns over simultaneous frames on all channels
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < CH; c++) ib[c] = irq_rise[c];
            base = nburst;
            fs_pulse(3'b111);
            for (int k = 0; k < 30; k++) begin
                rmask = CH'($urandom_range(0, 7));
                ch_req_i = rmask;
                tick($urandom_range(5, 30));
            end
            ch_req_i = 3'b111;
            wait_nburst(base + CH * FB, 3000, "t5_bursts");
            for (int c = 0; c < CH; c++)
                wait_irq(c, ib[c] + 1, 300, $sformatf("t5_irq%0d", c));
        end

        // Reset while a burst is in progress
        ch_req_i = 3'b001;
        fs_pulse(3'b001);
        t = 0;
        while (!fdma_wbusy && t < 1000) begin
            @(negedge ui_clk);
            drain();
            t++;
        end
        tick(2);
        chk("t6_busy", 64'(fdma_wbusy), 64'(1));
        ui_rst = 1'b1;
        @(negedge ui_clk);
        chk("t6_wareq", 64'(fdma_wareq), 64'(0));
        chk("t6_grant", 64'(grant_o), 64'(0));
        chk("t6_buf", 64'(ch_buf_o), 64'(0));
        chk("t6_flags", 64'({ch_irq_o, ch_ovf_o, ch_fifo_rst_o, ch_rd_o}), 64'(0));
        chk("t6_waddr", 64'(fdma_waddr), 64'(0));
        repeat (2) @(negedge ui_clk);
        ui_rst = 1'b0;
        lg_ch.delete();
        lg_ad.delete();
        for (int c = 0; c < CH; c++) begin
            mbuf[c] = 0; mbcnt[c] = 0;
        end
        @(negedge ui_clk);
        ch_req_i = 3'b010;
        i0 = irq_rise[1];
        fs_pulse(3'b010);
        tick(2);
        chk("t6_buf_after", 64'(buf_of(1)), 64'(1));
        wait_nburst(nburst + FB, 2000, "t6_bursts");
        wait_irq(1, i0 + 1, 200, "t6_irq");

        chk("rd_strobe", 64'(rd_bad), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
